// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, optional multi-cycle mul stall,
// branch/jump flush and a saturating stall-cycle counter.
// Optional feature: define MUL_MULTICYCLE_EN to enable the multi-cycle mul
// stall. When it is undefined, ID_IsMul is ignored and Busy is held at 0.
module pipeline_hazard_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_IsMul,
  input  logic        ID_Jump,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BranchTaken,
  input  logic        ClrCount,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        Busy,
  output logic [15:0] StallCount
);

  localparam int unsigned MUL_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_WAIT = 1'b1;

  localparam logic [MUL_W-1:0] MUL_LOAD = MUL_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(16'hFFFF);

  logic [0:0]       state_q, state_d;
  logic [MUL_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use_c;
  logic mul_req_c;
  logic stall_c;
  logic pc_write_c;
  logic ifid_write_c;
  logic ifid_flush_c;
  logic idex_bubble_c;

  // Load in EX writes a register the ID instruction reads; r0 never hazards
  assign load_use_c = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

`ifdef MUL_MULTICYCLE_EN
  assign mul_req_c = ID_IsMul;
`else
  logic unused_is_mul;
  assign unused_is_mul = ID_IsMul;
  assign mul_req_c     = 1'b0;
`endif

  // Next-state and raw pipeline-control decode, in priority order
  always_comb begin
    state_d       = state_q;
    mul_cnt_d     = mul_cnt_q;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;

    if (EX_BranchTaken) begin
      // Redirect fetch; squash IF/ID and the ID instruction; abort any mul wait
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      state_d       = ST_RUN;
      mul_cnt_d     = '0;
    end else if (load_use_c) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mul_req_c) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
            mul_cnt_d     = MUL_LOAD;
            state_d       = ST_MUL_WAIT;
          end else if (ID_Jump) begin
            ifid_flush_c = 1'b1;
          end
        end
        ST_MUL_WAIT: begin
          if (mul_cnt_q != '0) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
            mul_cnt_d     = mul_cnt_q - MUL_W'(1);
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d   = ST_RUN;
          mul_cnt_d = '0;
        end
      endcase
    end
  end

  // Output drive; reset forces a frozen, squashing pipeline
  always_comb begin
    PCWrite     = 1'b0;
    IFID_Write  = 1'b0;
    IFID_Flush  = 1'b1;
    IDEX_Bubble = 1'b1;
    Busy        = 1'b0;
    if (Rst) begin
      PCWrite     = pc_write_c;
      IFID_Write  = ifid_write_c;
      IFID_Flush  = ifid_flush_c;
      IDEX_Bubble = idex_bubble_c;
`ifdef MUL_MULTICYCLE_EN
      Busy        = (state_q != ST_RUN);
`endif
    end
  end

  // A stall is a full freeze with a bubble; flush cycles do not count
  assign stall_c = !pc_write_c && !ifid_write_c && idex_bubble_c && !ifid_flush_c;

  // Saturating stall counter; clear beats increment
  always_comb begin
    stall_count_d = stall_count_q;
    if (ClrCount) begin
      stall_count_d = '0;
    end else if (stall_c && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // State, mul countdown and stall counter registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= ST_RUN;
      mul_cnt_q     <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mul_cnt_q     <= mul_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl. Follows the
// MUL_MULTICYCLE_EN setting of the build for the mul-specific steps.
module tb_pipeline_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, ID_IsMul, ID_Jump, EX_MemRead, EX_BranchTaken, ClrCount;
  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Busy;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_IsMul(ID_IsMul),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .EX_BranchTaken(EX_BranchTaken), .ClrCount(ClrCount),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .Busy(Busy), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Busy}
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Busy};
    check(tag, 16'(obs), 16'(exp));
  endtask

  task automatic idle();
    ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UsesRt = 1'b0; ID_IsMul = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_Rt = 5'd0; EX_BranchTaken = 1'b0; ClrCount = 1'b0;
  endtask

  task automatic load_use();
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  localparam logic [4:0] RUN_OK  = 5'b11000;
  localparam logic [4:0] STALL   = 5'b00010;
  localparam logic [4:0] FLUSH_J = 5'b11100;
  localparam logic [4:0] BRANCH  = 5'b11110;
  localparam logic [4:0] IN_RST  = 5'b00110;

  initial begin
    idle();
    #3;
    check_ctl("reset_outputs", IN_RST);
    check("reset_count", StallCount, 16'd0);
    load_use();
    #1;
    check_ctl("reset_outputs_with_hazard", IN_RST);
    idle();
    cyc();
    Rst = 1'b1;

    // First edge after release: plain RUN
    #1; check_ctl("first_after_reset", RUN_OK);
    cyc(); check("count_idle", StallCount, 16'd0);

    // Load-use on rs: exactly one stall cycle
    load_use();
    #1; check_ctl("load_use_rs", STALL);
    cyc(); check("count_load_use", StallCount, 16'd1);
    idle();
    #1; check_ctl("after_load_use", RUN_OK);
    cyc(); check("count_after_load_use", StallCount, 16'd1);

    // r0 destination never hazards
    EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    #1; check_ctl("r0_no_hazard", RUN_OK);
    cyc();

    // rt match ignored unless rt is read
    idle(); EX_MemRead = 1'b1; EX_Rt = 5'd5; ID_Rt = 5'd5; ID_UsesRt = 1'b0;
    #1; check_ctl("rt_not_read", RUN_OK);
    cyc(); check("count_rt_not_read", StallCount, 16'd1);
    ID_UsesRt = 1'b1;
    #1; check_ctl("rt_read", STALL);
    cyc(); check("count_rt_read", StallCount, 16'd2);

    // Jump: flush only, not counted
    idle(); ID_Jump = 1'b1;
    #1; check_ctl("jump_flush", FLUSH_J);
    cyc(); check("count_jump", StallCount, 16'd2);

    // Branch beats load-use
    idle(); load_use(); EX_BranchTaken = 1'b1;
    #1; check_ctl("branch_over_load_use", BRANCH);
    cyc(); check("count_branch", StallCount, 16'd2);
    idle();
    #1; check_ctl("run_after_branch", RUN_OK);
    cyc();

    // Load-use beats jump
    load_use(); ID_Jump = 1'b1;
    #1; check_ctl("load_use_over_jump", STALL);
    cyc(); check("count_lu_over_jump", StallCount, 16'd3);

`ifdef MUL_MULTICYCLE_EN
    // Mul holds ID for four cycles
    idle(); ID_IsMul = 1'b1;
    #1; check_ctl("mul_c1", STALL);
    cyc(); check_ctl("mul_c2", 5'b00011);
    cyc(); check_ctl("mul_c3", 5'b00011);
    cyc(); check_ctl("mul_c4", 5'b11001);
    cyc(); idle();
    #1; check_ctl("mul_done", RUN_OK);
    check("count_mul", StallCount, 16'd6);
    cyc();

    // Branch on the first MUL_WAIT cycle aborts it
    ID_IsMul = 1'b1;
    #1; check_ctl("mul_b_c1", STALL);
    cyc(); EX_BranchTaken = 1'b1;
    #1; check_ctl("branch_in_mul_wait", 5'b11111);
    cyc(); idle();
    #1; check_ctl("run_after_mul_abort", RUN_OK);
    check("count_mul_abort", StallCount, 16'd7);
    cyc();
`else
    // Mul ignored when the multi-cycle feature is off
    idle(); ID_IsMul = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; check_ctl("mul_ignored", RUN_OK);
      cyc();
    end
    idle();
    check("count_mul_ignored", StallCount, 16'd3);
`endif

    // Clear wins over a simultaneous stall
    load_use(); ClrCount = 1'b1;
    #1; check_ctl("clear_during_stall", STALL);
    cyc(); check("count_cleared", StallCount, 16'd0);

    // Saturation: hold the stall past 0xFFFF
    ClrCount = 1'b0;
    repeat (65534) @(posedge Clk);
    #1; check("count_fffe", StallCount, 16'hFFFE);
    cyc(); check("count_ffff", StallCount, 16'hFFFF);
    cyc(); cyc(); check("count_saturated", StallCount, 16'hFFFF);
    ClrCount = 1'b1;
    cyc(); check("count_clear_from_sat", StallCount, 16'd0);
    ClrCount = 1'b0;
    cyc(); check("count_after_clear", StallCount, 16'd1);

`ifdef MUL_MULTICYCLE_EN
    // Reset while waiting on mul with one cycle of countdown left
    idle(); ID_IsMul = 1'b1;
    cyc(); cyc();
    #1; check_ctl("mul_wait_cnt1", 5'b00011);
`endif
    Rst = 1'b0;
    #1; check_ctl("async_reset_outputs", IN_RST);
    check("async_reset_count", StallCount, 16'd0);
    cyc(); idle();
    Rst = 1'b1;
    #1; check_ctl("run_after_reset", RUN_OK);
    cyc(); check("count_after_reset", StallCount, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named as listed below.
REQ-002 Clk  input  1  rising-edge clock.
REQ-003 Rst  input  1  asynchronous reset, active-low.
REQ-004 ID_Rs  input  5  rs field of the instruction in ID.
REQ-005 ID_Rt  input  5  rt field of the instruction in ID.
REQ-006 ID_UsesRt  input  1  the ID instruction reads rt.
REQ-007 ID_IsMul  input  1  the ID instruction is mul.
REQ-008 ID_Jump  input  1  the ID instruction is j, jal or jr.
REQ-009 EX_MemRead  input  1  the EX instruction is a load (lw, lh or lb).
REQ-010 EX_Rt  input  5  destination register of the EX load.
REQ-011 EX_BranchTaken  input  1  a branch resolved taken in EX.
REQ-012 ClrCount  input  1  synchronous clear of StallCount.
REQ-013 PCWrite  output  1  PC register enable.
REQ-014 IFID_Write  output  1  IF/ID register enable.
REQ-015 IFID_Flush  output  1  zero the IF/ID register.
REQ-016 IDEX_Bubble  output  1  force ID/EX WB and M controls to zero.
REQ-017 Busy  output  1  state is not RUN.
REQ-018 StallCount  output  16  count of stall cycles.

Function
REQ-019 State SHALL be registered, with states RUN and MUL_WAIT, plus a 2-bit down-counter MulCnt.
REQ-020 Outputs other than StallCount SHALL be combinational from state, MulCnt and inputs. Zero-latency response is required.
REQ-021 A load-use hazard SHALL be: EX_MemRead=1, EX_Rt!=0, and either EX_Rt==ID_Rs or (ID_UsesRt=1 and EX_Rt==ID_Rt).
REQ-022 Stall SHALL mean PCWrite=0, IFID_Write=0, IDEX_Bubble=1 and IFID_Flush=0.
REQ-023 Priority within any cycle SHALL be: EX_BranchTaken, then load-use, then mul, then jump.
REQ-024 EX_BranchTaken=1 SHALL give IFID_Flush=1, IDEX_Bubble=1, PCWrite=1 and IFID_Write=1. The next state SHALL be RUN and MulCnt SHALL be 0, aborting any MUL_WAIT.
REQ-025 In RUN, a load-use hazard SHALL stall exactly that cycle, with no state change.
REQ-026 In RUN with ID_IsMul=1 and no higher event, the block SHALL stall, load MulCnt=2 and go to MUL_WAIT (only when MUL_MULTICYCLE_EN is defined).
REQ-027 In MUL_WAIT with MulCnt!=0, the block SHALL stall and decrement MulCnt.
REQ-028 In MUL_WAIT with MulCnt==0, the block SHALL drive all enables with no flush or bubble and go to RUN. Mul therefore occupies ID for exactly 4 cycles.
REQ-029 In RUN with ID_Jump=1 and no higher event, the block SHALL set IFID_Flush=1 and PCWrite=1 for one cycle, with no bubble.
REQ-030 With no event, the outputs SHALL be PCWrite=1, IFID_Write=1, IFID_Flush=0 and IDEX_Bubble=0.
REQ-031 StallCount SHALL increment on each clock edge where the stall condition (REQ-022) holds. Flush-only cycles SHALL NOT count.
REQ-032 StallCount SHALL saturate at 0xFFFF.
REQ-033 ClrCount=1 SHALL zero StallCount at the next edge. Clear SHALL win over a simultaneous increment.

Reset
REQ-034 While Rst=0, the block SHALL hold state=RUN, MulCnt=0 and StallCount=0.
REQ-035 While Rst=0, the outputs SHALL be PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1 and Busy=0.
REQ-036 Reset asserted mid-MUL_WAIT SHALL abort immediately (asynchronously), with no residual stall after release.
REQ-037 The first edge after Rst rises SHALL behave as RUN with no event pending.

Configuration
REQ-038 With macro MUL_MULTICYCLE_EN defined, mul SHALL follow REQ-026 to REQ-028.
REQ-039 With MUL_MULTICYCLE_EN undefined, ID_IsMul SHALL be ignored, MUL_WAIT SHALL be unreachable and Busy SHALL be constantly 0.

Verification
REQ-040 Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8 for one cycle -> exactly one cycle of PCWrite=0, IDEX_Bubble=1, and StallCount 0->1.
REQ-041 EX_Rt=0 load-use check: EX_MemRead=1, EX_Rt=0, ID_Rs=0 -> no stall.
REQ-042 Rt not read: ID_UsesRt=0, EX_Rt=ID_Rt=5 -> no stall.
REQ-043 Mul: ID_IsMul=1 (macro defined) -> PCWrite low for 3 cycles, high on the 4th, Busy high for 3 cycles, StallCount=3.
REQ-044 Mul undefined: the same stimulus with the macro undefined -> no stall.
REQ-045 Branch priority: EX_BranchTaken=1 together with a load-use hazard, or on the first MUL_WAIT cycle -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, and RUN next cycle.
REQ-046 Saturation and clear: preload StallCount near 0xFFFF and hold the stall -> holds at 0xFFFF. ClrCount=1 during a stall -> 0.
REQ-047 Reset: Rst low during MUL_WAIT with MulCnt=1 -> immediate RUN, StallCount=0, and the reset output values of REQ-035.
